// File: rtl/seg7_scan_driver.sv
// Multiplexed 4-digit seven-segment scan driver with blanking gaps and
// frame-synchronous (tear-free) double-buffered display updates.
module seg7_scan_driver #(
    parameter int unsigned SCAN_DIV   = 100000,
    parameter int unsigned GAP_CYCLES = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] data_i,
    input  logic [3:0]  dp_i,
    input  logic [3:0]  blank_i,
    input  logic        we_i,
    output logic [7:0]  seg,
    output logic [3:0]  an,
    output logic        update_pending_o,
    output logic        frame_done_o
);

    typedef enum logic {SHOW, GAP} state_t;

    localparam logic [19:0] SHOW_LAST = 20'(SCAN_DIV - 1);
    localparam logic [19:0] GAP_LAST  = 20'(GAP_CYCLES - 1);
    localparam bit          NO_GAP    = (GAP_CYCLES == 0);

    state_t      state_q, state_d;
    logic [1:0]  digit_q, digit_d;
    logic [19:0] cnt_q, cnt_d;
    logic        run_q;

    logic [15:0] pend_data_q;
    logic [3:0]  pend_dp_q, pend_blank_q;
    logic        pend_valid_q;

    logic [15:0] shadow_data_q, shadow_data_d;
    logic [3:0]  shadow_dp_q, shadow_dp_d, shadow_blank_q, shadow_blank_d;

    logic        boundary, last_d;
    logic [7:0]  seg_d;
    logic [3:0]  an_d;
    logic [3:0]  nibble;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
        endcase
    endfunction

    // The registers describe the slot on the pins in the current cycle;
    // run_q holds off the first advance so digit 0 appears right after reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q        <= SHOW;
            digit_q        <= 2'd0;
            cnt_q          <= 20'd0;
            run_q          <= 1'b0;
            pend_data_q    <= 16'h0000;
            pend_dp_q      <= 4'h0;
            pend_blank_q   <= 4'h0;
            pend_valid_q   <= 1'b0;
            shadow_data_q  <= 16'h0000;
            shadow_dp_q    <= 4'h0;
            shadow_blank_q <= 4'hF;
            seg            <= 8'hFF;
            an             <= 4'hF;
            frame_done_o   <= 1'b0;
        end else begin
            state_q        <= state_d;
            digit_q        <= digit_d;
            cnt_q          <= cnt_d;
            run_q          <= 1'b1;
            shadow_data_q  <= shadow_data_d;
            shadow_dp_q    <= shadow_dp_d;
            shadow_blank_q <= shadow_blank_d;
            seg            <= seg_d;
            an             <= an_d;
            frame_done_o   <= last_d;
            pend_valid_q   <= we_i | (pend_valid_q & ~boundary);
            if (we_i) begin
                pend_data_q  <= data_i;
                pend_dp_q    <= dp_i;
                pend_blank_q <= blank_i;
            end
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        state_d = state_q;
        digit_d = digit_q;
        cnt_d   = cnt_q + 20'd1;
        if (!run_q) begin
            state_d = SHOW;
            digit_d = 2'd0;
            cnt_d   = 20'd0;
        end else begin
            case (state_q)
                SHOW: if (cnt_q == SHOW_LAST) begin
                    cnt_d = 20'd0;
                    if (NO_GAP) digit_d = digit_q + 2'd1;
                    else        state_d = GAP;
                end
                GAP: if (cnt_q == GAP_LAST) begin
                    cnt_d   = 20'd0;
                    state_d = SHOW;
                    digit_d = digit_q + 2'd1;
                end
                default: state_d = SHOW;
            endcase
        end
    end

    always_comb begin
        boundary = run_q && (digit_q == 2'd3) &&
                   (NO_GAP ? (state_q == SHOW && cnt_q == SHOW_LAST)
                           : (state_q == GAP  && cnt_q == GAP_LAST));
        last_d   = (digit_d == 2'd3) &&
                   (NO_GAP ? (state_d == SHOW && cnt_d == SHOW_LAST)
                           : (state_d == GAP  && cnt_d == GAP_LAST));

        // Swap on the boundary edge itself so the first digit of the new frame already shows it.
        shadow_data_d  = shadow_data_q;
        shadow_dp_d    = shadow_dp_q;
        shadow_blank_d = shadow_blank_q;
        if (boundary && pend_valid_q) begin
            shadow_data_d  = pend_data_q;
            shadow_dp_d    = pend_dp_q;
            shadow_blank_d = pend_blank_q;
        end

        nibble = shadow_data_d[digit_d*4 +: 4];
        an_d   = 4'hF;
        seg_d  = 8'hFF;
        if (state_d == SHOW && !shadow_blank_d[digit_d]) begin
            an_d  = ~(4'b0001 << digit_d);
            seg_d = {~shadow_dp_d[digit_d], ~hex7(nibble)};
        end
    end

    assign update_pending_o = pend_valid_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver (SCAN_DIV=8, GAP_CYCLES=2, 40-cycle frame)
// with hand-computed segment codes and a per-cycle frame position tracker.
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data_i;
    logic [3:0]  dp_i;
    logic [3:0]  blank_i;
    logic        we_i;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic        update_pending_o;
    logic        frame_done_o;

    int n_cmp = 0;
    int n_err = 0;
    int pos   = 0;
    logic [7:0] exp_seg [4];
    logic [3:0] exp_blk;

    seg7_scan_driver #(.SCAN_DIV(8), .GAP_CYCLES(2)) dut (
        .clk              (clk),
        .rst              (rst),
        .data_i           (data_i),
        .dp_i             (dp_i),
        .blank_i          (blank_i),
        .we_i             (we_i),
        .seg              (seg),
        .an               (an),
        .update_pending_o (update_pending_o),
        .frame_done_o     (frame_done_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one cycle and check pins against the expected frame position.
    task automatic step();
        int d, r;
        logic [3:0] e_an;
        logic [7:0] e_seg;
        @(negedge clk);
        d = pos / 10;
        r = pos % 10;
        e_an  = 4'hF;
        e_seg = 8'hFF;
        if (r < 8 && !exp_blk[d]) begin
            e_an  = ~(4'b0001 << d);
            e_seg = exp_seg[d];
        end
        check($sformatf("an@%0d", pos), {28'd0, an}, {28'd0, e_an});
        check($sformatf("seg@%0d", pos), {24'd0, seg}, {24'd0, e_seg});
        check($sformatf("frame_done@%0d", pos), {31'd0, frame_done_o}, {31'd0, pos == 39});
        pos = (pos + 1) % 40;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic write(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] blk);
        data_i  = d;
        dp_i    = dp;
        blank_i = blk;
        we_i    = 1'b1;
        step();
        we_i    = 1'b0;
    endtask

    task automatic set_exp(input logic [7:0] s0, s1, s2, s3, input logic [3:0] blk);
        exp_seg[0] = s0; exp_seg[1] = s1; exp_seg[2] = s2; exp_seg[3] = s3;
        exp_blk    = blk;
    endtask

    initial begin
        rst = 1'b1; we_i = 1'b0; data_i = 16'h0; dp_i = 4'h0; blank_i = 4'h0;
        set_exp(8'hFF, 8'hFF, 8'hFF, 8'hFF, 4'hF);

        // Reset, then two dark frames.
        repeat (3) @(negedge clk);
        check("rst_an", {28'd0, an}, 32'hF);
        check("rst_seg", {24'd0, seg}, 32'hFF);
        check("rst_pending", {31'd0, update_pending_o}, 32'd0);
        check("rst_frame_done", {31'd0, frame_done_o}, 32'd0);
        rst = 1'b0;
        pos = 0;
        run(80);

        // Basic write: 12AF, dp on digit 2.
        run(1);
        check("pend_before_write", {31'd0, update_pending_o}, 32'd0);
        write(16'h12AF, 4'b0100, 4'b0000);
        check("pend_after_write", {31'd0, update_pending_o}, 32'd1);
        run(38);
        check("pend_at_boundary", {31'd0, update_pending_o}, 32'd1);
        set_exp(8'h8E, 8'h88, 8'h24, 8'hF9, 4'h0);
        run(40);
        check("pend_cleared", {31'd0, update_pending_o}, 32'd0);

        // Tear-free: 0000, then 8888 written during digit 2.
        run(1);
        write(16'h0000, 4'h0, 4'h0);
        run(38);
        set_exp(8'hC0, 8'hC0, 8'hC0, 8'hC0, 4'h0);
        run(20);
        write(16'h8888, 4'h0, 4'h0);
        check("tear_pend_set", {31'd0, update_pending_o}, 32'd1);
        run(19);
        check("tear_pend_hold", {31'd0, update_pending_o}, 32'd1);
        set_exp(8'h80, 8'h80, 8'h80, 8'h80, 4'h0);
        run(40);
        check("tear_pend_clear", {31'd0, update_pending_o}, 32'd0);

        // Boundary collision: 3333 pending, 5555 written on the frame_done cycle.
        run(1);
        write(16'h3333, 4'h0, 4'h0);
        run(38);
        check("coll_frame_done", {31'd0, frame_done_o}, 32'd1);
        check("coll_pend_pre", {31'd0, update_pending_o}, 32'd1);
        set_exp(8'hB0, 8'hB0, 8'hB0, 8'hB0, 4'h0);
        write(16'h5555, 4'h0, 4'h0);
        check("coll_pend_post", {31'd0, update_pending_o}, 32'd1);
        run(39);
        check("coll_pend_end", {31'd0, update_pending_o}, 32'd1);
        set_exp(8'h92, 8'h92, 8'h92, 8'h92, 4'h0);
        run(40);
        check("coll_pend_clear", {31'd0, update_pending_o}, 32'd0);

        // Blank mask: digits 1 and 3 dark.
        run(1);
        write(16'hFFFF, 4'h0, 4'b1010);
        run(38);
        set_exp(8'h8E, 8'h8E, 8'h8E, 8'h8E, 4'b1010);
        run(40);

        // Reset during digit 2 SHOW with a write pending.
        run(1);
        write(16'h1234, 4'h0, 4'h0);
        run(20);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_an", {28'd0, an}, 32'hF);
        check("mid_rst_seg", {24'd0, seg}, 32'hFF);
        check("mid_rst_pending", {31'd0, update_pending_o}, 32'd0);
        rst = 1'b0;
        pos = 0;
        set_exp(8'hFF, 8'hFF, 8'hFF, 8'hFF, 4'hF);
        run(40);
        check("post_rst_pending", {31'd0, update_pending_o}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Drives the board's 4-digit multiplexed seven-segment display (seg/an pins) from a 16-bit hex value written by the SOPC's memory-mapped output logic.
- Sits directly downstream of openmips_min_sopc's display register, between the core's bus-side write strobe and the FPGA pins.
- Provides per-digit scan timing, ghost-suppression gaps and tear-free update: new data is double-buffered and swapped only at a frame boundary.

Parameters:
SCAN_DIV, 100000, clock cycles each digit is lit (1 ms at 100 MHz); legal range 1..2^20-1.
GAP_CYCLES, 100, blanking cycles after each digit (all anodes off); 0 means no gap state.

Ports:
clk  in  1  system clock (clk_100mhz at top level)
rst  in  1  synchronous, active-high reset
data_i  in  16  four hex nibbles; [3:0] is digit 0 (rightmost)
dp_i  in  4  decimal point per digit, 1 = lit
blank_i  in  4  per-digit blank mask, 1 = digit dark
we_i  in  1  one-cycle write strobe; captures data_i/dp_i/blank_i
seg  out  8  segments, active-low; [0]=a … [6]=g, [7]=dp
an  out  4  anodes, active-low; an[d] selects digit d
update_pending_o  out  1  1 while a written value awaits the frame swap
frame_done_o  out  1  one-cycle pulse at each frame boundary

Behaviour:
- Registers:
  - pending set (data/dp/blank) plus pending_valid.
  - shadow set (the value being displayed).
  - FSM state SHOW/GAP, 2-bit digit index, 20-bit cycle counter.
- Reset (rst=1 at a rising edge):
  - seg=8'hFF, an=4'b1111, update_pending_o=0, frame_done_o=0.
  - shadow data=0, dp=0, blank=4'b1111 (display dark until first write).
  - pending cleared; state=SHOW, digit=0, counter=0.
  - Reset mid-frame aborts the scan and discards any pending write.
- seg/an are registered. From the first rising edge with rst=0, digit 0 is driven.
- SHOW(d):
  - an = ~(4'b0001<<d), or 4'b1111 if shadow blank[d].
  - seg = {~dp[d], ~hex7(nibble d)}, or 8'hFF if blank[d].
  - Held for exactly SCAN_DIV cycles, then go to GAP (or straight to the next digit if GAP_CYCLES=0).
- GAP: an=4'b1111, seg=8'hFF for exactly GAP_CYCLES cycles; then digit=(d+1) mod 4, return to SHOW.
- Frame boundary = the transition out of digit 3's slot (end of GAP, or end of SHOW when GAP_CYCLES=0).
  - frame_done_o pulses high for that one cycle.
  - If pending_valid, shadow<=pending and pending_valid clears.
- Frame period = 4*(SCAN_DIV+GAP_CYCLES) cycles; digit index wraps 3->0.
- hex7, active-high gfedcba: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
- we_i:
  - Captures into pending on the rising edge; sets pending_valid; update_pending_o=1 from the next cycle.
  - Back-to-back writes before a boundary: the last write wins; earlier ones are never displayed.
  - we_i in the same cycle as a frame boundary: shadow takes the old pending contents, pending takes the new input, and pending_valid stays 1 (the new value is shown one frame later).
  - we_i during rst is ignored.
- The displayed value never changes mid-frame (no tearing).

Test Plan:
(Parameters for all: SCAN_DIV=8, GAP_CYCLES=2.)
- Reset/dark: hold rst 3 cycles, release, no write.
  - Required: an=1111 and seg=FF for 2 full frames (80 cycles).
  - Required: frame_done_o pulses every 40 cycles, first at cycle 39 after release.
- Basic write: we_i with data_i=16'h12AF, dp_i=4'b0100, blank_i=0 during frame 0.
  - Required: from frame 1, digit0 an=1110 seg=8E for 8 cycles, then 2 gap cycles (1111/FF).
  - Required: digit1 seg=88, digit2 seg=24 (dp lit), digit3 seg=F9.
- Tear-free: write 16'h0000, then mid-frame write 16'h8888 at digit 2.
  - Required: the current frame finishes showing 0000 (seg=C0); the next frame shows seg=80.
  - Required: update_pending_o=1 from the cycle after the write until the boundary.
- Boundary collision: we_i with 16'h5555 exactly on the frame_done_o cycle while 16'h3333 is pending.
  - Required: the next frame shows 3 (seg=B0); the following frame shows 5 (seg=92); update_pending_o stays 1 across the collision.
- Blank mask: data 16'hFFFF, blank_i=4'b1010.
  - Required: digits 1 and 3 show an=1111 seg=FF during their SHOW slots; digits 0 and 2 show seg=8E.
- Reset mid-operation: assert rst during digit 2 SHOW with a write pending.
  - Required: next cycle an=1111 seg=FF, update_pending_o=0; the display stays dark after release.
